switch_sample_ctrl: RTL and testbench

//   Sequences sampling of the 16 EGO1 slide switches for the CPU. A debounced press of the confirm

---
 rtl/switch_sample_ctrl_pkg.sv | 18 +
 rtl/switch_sample_ctrl_if.sv | 26 ++
 rtl/switch_sample_ctrl_btn_debounce.sv | 65 ++++++
 rtl/switch_sample_ctrl.sv | 84 ++++++++
 tb/tb_switch_sample_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/switch_sample_ctrl_pkg.sv
// Shared constants for the switch sampling controller: debounce FSM encoding,
// register addresses and status-word bit positions.
package switch_sample_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic SWCTL_ADDR_DATA = 1'b0;
  localparam logic SWCTL_ADDR_STAT = 1'b1;

  localparam int STAT_VALID_BIT   = 0;
  localparam int STAT_OVERRUN_BIT = 1;

endpackage

// File: rtl/switch_sample_ctrl_if.sv
// CPU-side register bus between memorio and the switch sampling controller.
interface swctl_if #(
  parameter int DW = 16
);
  // Handshake: a read request is the level swctlcs && swctlread; there is no
  // ready. Data is loaded on the next negedge and read side-effects apply on
  // the next posedge, for as long as the request stays asserted.
  logic          swctlcs;
  logic          swctlread;
  logic          swctladdr;
  logic [DW-1:0] swctl_rdata;

  modport master (
    output swctlcs,
    output swctlread,
    output swctladdr,
    input  swctl_rdata
  );

  modport slave (
    input  swctlcs,
    input  swctlread,
    input  swctladdr,
    output swctl_rdata
  );
endinterface

// File: rtl/switch_sample_ctrl_btn_debounce.sv
// Confirm-button synchronizer and press/release debounce FSM; emits a single
// press pulse on the edge where a press is accepted.
module switch_sample_ctrl_btn_debounce
  import switch_sample_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 15
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_btn_raw,
  output logic   o_press_pulse,
  output state_t o_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_btn_meta;
  logic             r_btn_s;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
      r_state    <= IDLE;
      r_cnt      <= '0;
    end else begin
      r_btn_meta <= i_btn_raw;
      r_btn_s    <= r_btn_meta;
      case (r_state)
        IDLE: begin
          if (r_btn_s) begin
            r_state <= PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!r_btn_s)               r_state <= IDLE;
          else if (r_cnt == CNT_LAST) r_state <= HELD;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        HELD: begin
          if (!r_btn_s) begin
            r_state <= REL_CHK;
            r_cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (r_btn_s)                r_state <= HELD;
          else if (r_cnt == CNT_LAST) r_state <= IDLE;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded from the PRESS_CHK->HELD condition so the capture lands on the
  // same edge as the transition rather than one cycle later.
  assign o_press_pulse = (r_state == PRESS_CHK) && r_btn_s && (r_cnt == CNT_LAST);
  assign o_state       = r_state;

endmodule

// File: rtl/switch_sample_ctrl.sv
// Captures a switch snapshot on each debounced confirm press and exposes it,
// plus valid/overrun status, to the CPU over the memorio register bus.
module switch_sample_ctrl
  import switch_sample_ctrl_pkg::*;
#(
  parameter int DW         = 16,
  parameter int DEB_CYCLES = 20000,
  parameter int CNT_W      = 15
) (
  input  logic          swctlclk,
  input  logic          swctlrst,
  input  logic [DW-1:0] sw_raw,
  input  logic          btn_raw,
  swctl_if.slave        bus,
  output logic          sample_valid,
  output logic          overrun,
  output state_t        dbg_state
);

  logic [DW-1:0] r_sw_meta;
  logic [DW-1:0] r_sw_s;
  logic [DW-1:0] r_snapshot;
  logic          r_sample_valid;
  logic          r_overrun;
  logic [DW-1:0] r_rdata;

  logic          w_press_pulse;
  logic          w_rd;
  logic          w_rd_data;
  logic          w_rd_stat;
  logic [DW-1:0] w_status;

  switch_sample_ctrl_btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_btn_debounce (
    .clk           (swctlclk),
    .rst_n         (swctlrst),
    .i_btn_raw     (btn_raw),
    .o_press_pulse (w_press_pulse),
    .o_state       (dbg_state)
  );

  assign w_rd      = bus.swctlcs && bus.swctlread;
  assign w_rd_data = w_rd && (bus.swctladdr == SWCTL_ADDR_DATA);
  assign w_rd_stat = w_rd && (bus.swctladdr == SWCTL_ADDR_STAT);

  always_comb begin
    w_status                   = '0;
    w_status[STAT_VALID_BIT]   = r_sample_valid;
    w_status[STAT_OVERRUN_BIT] = r_overrun;
  end

  // A capture always beats a clearing read on the same edge.
  always_ff @(posedge swctlclk or negedge swctlrst) begin
    if (!swctlrst) begin
      r_sw_meta      <= '0;
      r_sw_s         <= '0;
      r_snapshot     <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_sw_meta      <= sw_raw;
      r_sw_s         <= r_sw_meta;
      if (w_press_pulse) r_snapshot <= r_sw_s;
      r_sample_valid <= w_press_pulse || (r_sample_valid && !w_rd_data);
      r_overrun      <= (w_press_pulse && r_sample_valid) || (r_overrun && !w_rd_stat);
    end
  end

  // Read data launches on the falling edge to meet memorio's sampling point.
  always_ff @(negedge swctlclk or negedge swctlrst) begin
    if (!swctlrst) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= bus.swctladdr ? w_status : r_snapshot;
    end
  end

  assign bus.swctl_rdata = r_rdata;
  assign sample_valid    = r_sample_valid;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_switch_sample_ctrl.sv
// Directed bench for switch_sample_ctrl with a short debounce window.
module tb_switch_sample_ctrl;
  import switch_sample_ctrl_pkg::*;

  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] sw_raw;
  logic          btn_raw;
  logic          sample_valid;
  logic          overrun;
  state_t        dbg_state;

  int n_checks;
  int n_errors;

  swctl_if #(.DW(DW)) bus ();

  switch_sample_ctrl #(
    .DW         (DW),
    .DEB_CYCLES (4),
    .CNT_W      (15)
  ) dut (
    .swctlclk     (clk),
    .swctlrst     (rst_n),
    .sw_raw       (sw_raw),
    .btn_raw      (btn_raw),
    .bus          (bus),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_PRESS, OP_READ, OP_CS_ONLY, OP_RD_ONLY} op_t;
  typedef struct {
    op_t           op;
    logic [DW-1:0] sw;
    logic          addr;
    logic [DW-1:0] exp_rdata;
    logic          exp_sv;
    logic          exp_ov;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic bus_cycle(input logic cs, input logic rd, input logic addr);
    bus.swctlcs   = cs;
    bus.swctlread = rd;
    bus.swctladdr = addr;
    tick();
    bus.swctlcs   = 1'b0;
    bus.swctlread = 1'b0;
  endtask

  task automatic press(input logic [DW-1:0] val);
    sw_raw  = val;
    btn_raw = 1'b1;
    ticks(10);
    btn_raw = 1'b0;
    ticks(10);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    sw_raw        = '0;
    btn_raw       = 1'b0;
    bus.swctlcs   = 1'b0;
    bus.swctlread = 1'b0;
    bus.swctladdr = 1'b0;

    vecs[0] = '{OP_PRESS,   16'h0001, 1'b0, 16'hA5C3, 1'b1, 1'b0};
    vecs[1] = '{OP_PRESS,   16'h0002, 1'b0, 16'hA5C3, 1'b1, 1'b1};
    vecs[2] = '{OP_RD_ONLY, 16'h0000, 1'b1, 16'hA5C3, 1'b1, 1'b1};
    vecs[3] = '{OP_CS_ONLY, 16'h0000, 1'b0, 16'hA5C3, 1'b1, 1'b1};
    vecs[4] = '{OP_READ,    16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[5] = '{OP_READ,    16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[6] = '{OP_READ,    16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{OP_PRESS,   16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{OP_READ,    16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[9] = '{OP_READ,    16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    ticks(2);
    check("rst_sv", 32'(sample_valid), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_rdata", 32'(bus.swctl_rdata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    ticks(2);

    // reset asserted while the press is still being qualified
    sw_raw  = 16'hFFFF;
    btn_raw = 1'b1;
    ticks(4);
    check("t1_in_press_chk", 32'(dbg_state), 32'(PRESS_CHK));
    rst_n = 1'b0;
    #1;
    check("t1_rst_state", 32'(dbg_state), 32'(IDLE));
    check("t1_rst_sv", 32'(sample_valid), 32'd0);
    check("t1_rst_ov", 32'(overrun), 32'd0);
    check("t1_rst_rdata", 32'(bus.swctl_rdata), 32'd0);
    btn_raw = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(15);
    check("t1_no_capture_sv", 32'(sample_valid), 32'd0);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t1_snapshot_zero", 32'(bus.swctl_rdata), 32'd0);

    // capture latency: valid on the 7th posedge after the rise
    sw_raw  = 16'hA5C3;
    btn_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) check("t2_sv_at_6", 32'(sample_valid), 32'd0);
    end
    check("t2_sv_at_7", 32'(sample_valid), 32'd1);
    ticks(3);
    btn_raw = 1'b0;
    ticks(10);
    check("t2_state_idle", 32'(dbg_state), 32'(IDLE));
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t2_rdata", 32'(bus.swctl_rdata), 32'h0000A5C3);
    check("t2_sv_cleared", 32'(sample_valid), 32'd0);

    // bounce: 2 high / 2 low never reaches the debounce threshold
    sw_raw = 16'h1111;
    for (int i = 0; i < 6; i++) begin
      btn_raw = 1'b1;
      ticks(2);
      btn_raw = 1'b0;
      ticks(2);
    end
    ticks(6);
    check("t3_sv", 32'(sample_valid), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(IDLE));

    // table: presses, reads and non-read bus cycles
    for (int i = 0; i < 10; i++) begin
      case (vecs[i].op)
        OP_PRESS:   press(vecs[i].sw);
        OP_READ:    bus_cycle(1'b1, 1'b1, vecs[i].addr);
        OP_CS_ONLY: bus_cycle(1'b1, 1'b0, vecs[i].addr);
        OP_RD_ONLY: bus_cycle(1'b0, 1'b1, vecs[i].addr);
        default:    tick();
      endcase
      check($sformatf("vec%0d_rdata", i), 32'(bus.swctl_rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_sv", i), 32'(sample_valid), 32'(vecs[i].exp_sv));
      check($sformatf("vec%0d_ov", i), 32'(overrun), 32'(vecs[i].exp_ov));
    end

    // long hold: one capture only, short release bounce ignored
    sw_raw  = 16'h5A5A;
    btn_raw = 1'b1;
    ticks(10);
    check("t5_sv_captured", 32'(sample_valid), 32'd1);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t5_rdata", 32'(bus.swctl_rdata), 32'h00005A5A);
    sw_raw = 16'h7777;
    ticks(89);
    check("t5_no_recapture", 32'(sample_valid), 32'd0);
    check("t5_state_held", 32'(dbg_state), 32'(HELD));
    btn_raw = 1'b0;
    ticks(3);
    btn_raw = 1'b1;
    ticks(10);
    check("t5_bounce_held", 32'(dbg_state), 32'(HELD));
    check("t5_bounce_sv", 32'(sample_valid), 32'd0);
    btn_raw = 1'b0;
    ticks(10);
    check("t5_release_idle", 32'(dbg_state), 32'(IDLE));
    check("t5_release_sv", 32'(sample_valid), 32'd0);
    check("t5_ov", 32'(overrun), 32'd0);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_STAT);
    check("t5_stat", 32'(bus.swctl_rdata), 32'd0);

    // snapshot read on the capture edge
    sw_raw  = 16'h1234;
    btn_raw = 1'b1;
    ticks(6);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t6_sv_kept", 32'(sample_valid), 32'd1);
    check("t6_old_rdata", 32'(bus.swctl_rdata), 32'h00005A5A);
    check("t6_ov", 32'(overrun), 32'd0);
    ticks(3);
    btn_raw = 1'b0;
    ticks(10);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t6_new_rdata", 32'(bus.swctl_rdata), 32'h00001234);
    check("t6_sv_cleared", 32'(sample_valid), 32'd0);

    // status read on a capture that sets overrun
    press(16'h00FF);
    sw_raw  = 16'h0F0F;
    btn_raw = 1'b1;
    ticks(6);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_STAT);
    check("t7_ov_kept", 32'(overrun), 32'd1);
    check("t7_stat_before", 32'(bus.swctl_rdata), 32'd1);
    ticks(3);
    btn_raw = 1'b0;
    ticks(10);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_STAT);
    check("t7_stat", 32'(bus.swctl_rdata), 32'd3);
    check("t7_ov_cleared", 32'(overrun), 32'd0);
    bus_cycle(1'b1, 1'b1, SWCTL_ADDR_DATA);
    check("t7_rdata", 32'(bus.swctl_rdata), 32'h00000F0F);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
